// File: rtl/fibonacci_checker.sv
// Receive-side Fibonacci stream checker: compares incoming terms against an
// internally generated series and reports pass, mismatch or overflow.
module fibonacci_checker #(
  parameter int WIDTH = 8,
  parameter int N     = 10,
  parameter int SEED0 = 1,
  parameter int SEED1 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             ovf,
  output logic [7:0]       err_idx,
  output logic [7:0]       count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_FAIL
  } state_e;

  // One guard bit above the term width records that a term no longer fits.
  typedef logic [WIDTH:0] term_t;

  localparam term_t      SEED0_T = term_t'(SEED0);
  localparam term_t      SEED1_T = term_t'(SEED1);
  localparam logic [7:0] N_TERMS = 8'(N);

  state_e     state_q, state_d;
  term_t      exp_q, exp_d;
  term_t      nxt_q, nxt_d;
  logic [7:0] count_q, count_d;
  logic [7:0] err_idx_q, err_idx_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;
  logic       ovf_q, ovf_d;

  logic       beat;
  logic       match;
  logic       exp_ovf;
  logic       last_term;
  logic [7:0] count_inc;
  term_t      sum_raw;
  term_t      sum_sat;

  assign beat      = in_valid && in_ready;
  assign match     = (in_data == exp_q[WIDTH-1:0]);
  assign exp_ovf   = exp_q[WIDTH];
  assign count_inc = count_q + 8'd1;
  assign last_term = (count_inc == N_TERMS);
  assign sum_raw   = exp_q + nxt_q;

  // Once either operand has overflowed the guard bit must stay set, even if
  // the raw sum wraps it back to zero.
  assign sum_sat = {sum_raw[WIDTH] | exp_q[WIDTH] | nxt_q[WIDTH], sum_raw[WIDTH-1:0]};

  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (start) begin
          state_d = S_RUN;
        end else if (exp_ovf) begin
          state_d = S_FAIL;
        end else if (beat) begin
          if (!match)         state_d = S_FAIL;
          else if (last_term) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    exp_d     = exp_q;
    nxt_d     = nxt_q;
    count_d   = count_q;
    err_idx_d = err_idx_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ovf_d     = ovf_q;

    if (start) begin
      exp_d     = SEED0_T;
      nxt_d     = SEED1_T;
      count_d   = 8'd0;
      err_idx_d = 8'd0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      ovf_d     = 1'b0;
    end else if (state_q == S_RUN) begin
      // Overflow wins over any beat offered in the same cycle.
      if (exp_ovf) begin
        fail_d    = 1'b1;
        done_d    = 1'b1;
        ovf_d     = 1'b1;
        err_idx_d = count_q;
      end else if (beat) begin
        if (match) begin
          count_d = count_inc;
          exp_d   = nxt_q;
          nxt_d   = sum_sat;
          if (last_term) begin
            done_d = 1'b1;
            pass_d = 1'b1;
          end
        end else begin
          fail_d    = 1'b1;
          done_d    = 1'b1;
          err_idx_d = count_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q     <= '0;
      nxt_q     <= '0;
      count_q   <= 8'd0;
      err_idx_q <= 8'd0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      exp_q     <= exp_d;
      nxt_q     <= nxt_d;
      count_q   <= count_d;
      err_idx_q <= err_idx_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    busy     = (state_q == S_RUN);
    in_ready = (state_q == S_RUN) && !start;
  end

  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign ovf      = ovf_q;
  assign err_idx  = err_idx_q;
  assign count    = count_q;
  assign expected = exp_q[WIDTH-1:0];

endmodule

// File: doc/fibonacci_checker.md
Name: fibonacci_checker

Overview:
Stream consumer that checks an incoming sequence of terms against the Fibonacci series, seeded with SEED0 and SEED1. It is the receive-side counterpart to the Fibonacci term generator. It accepts terms over a valid/ready handshake, compares each term to an internally computed expected value, and reports pass, fail, or overflow once N terms have been checked or the first mismatch occurs.

Parameters:
WIDTH, 8, term width in bits (in_data, expected)
N, 10, number of terms to check; legal range 2..255
SEED0, 1, expected value of term 0
SEED1, 1, expected value of term 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins or restarts a check run
in_valid  input  1  producer has a term on in_data
in_data  input  WIDTH  term value
in_ready  output  1  checker accepts the term this cycle
busy  output  1  run in progress (state RUN)
done  output  1  run finished, held until the next start or reset
pass  output  1  all N terms matched, held with done
fail  output  1  mismatch or overflow, held with done
ovf  output  1  fail was caused by an expected term not fitting in WIDTH bits
err_idx  output  8  index of the failing term, valid when fail=1
count  output  8  number of terms matched in the current or last run
expected  output  WIDTH  expected value of the next term (of the failing term once failed)

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE. All outputs are 0. The internal exp/nxt registers are 0.
- Internal registers:
  - exp and nxt are each WIDTH+1 bits; the extra MSB is the overflow bit.
  - Sum rule: nxt_new = exp + nxt in WIDTH+1 bits. It saturates: if either operand MSB is set, the result MSB is forced to 1.
- The expected port is exp[WIDTH-1:0].
- in_ready is combinational: (state==RUN) && !start.
- A beat is accepted when in_valid && in_ready.
- States and transitions: IDLE, RUN, DONE, FAIL.
- IDLE:
  - start -> RUN.
  - Load exp=SEED0 and nxt=SEED1.
  - Clear count, err_idx, done, pass, fail and ovf.
- RUN:
  - busy=1.
  - On an accepted beat where in_data == exp[WIDTH-1:0]:
    - count <= count+1, exp <= nxt, nxt <= exp+nxt.
    - If count+1 == N -> DONE. Set done=1 and pass=1 on the next edge.
  - On an accepted beat where in_data differs -> FAIL.
    - Set fail=1, done=1, err_idx=count.
    - count and exp hold, so expected shows the value that was wanted.
  - Overflow: if the exp MSB is set while in RUN, go to FAIL on that edge without accepting.
    - Set ovf=1, err_idx=count.
    - in_ready is still 1 during that one cycle. A beat accepted in that cycle is still counted as failed: the overflow takes precedence, and no match is possible.
  - Cycles with no accepted beat change nothing.
- DONE / FAIL:
  - busy=0, in_ready=0.
  - All flags and counters hold.
  - start -> re-initialise as from IDLE and enter RUN.
- start while in RUN:
  - Abort and restart. Same initialisation as from IDLE.
  - A beat presented in the same cycle is not accepted (in_ready=0).
- Latency: pass/fail/done/ovf rise one clock after the deciding beat edge. A result needs no further input beats.
- pass and fail are never both 1. done = pass | fail.
- Reset mid-run: immediate return to IDLE with all outputs 0. No partial result is retained.

Test Plan:
- Default params; start, then feed 1,1,2,3,5,8,13,21,34,55 back-to-back -> pass=1, done=1, count=10, fail=0. in_ready drops the cycle after the 10th beat.
- Default params; feed 1,1,2,3,6 -> fail=1, err_idx=4, expected=5, count=4, ovf=0. Further in_valid beats are not accepted.
- Same correct series as the first scenario, with in_valid low on random cycles (2–5 idle cycles between beats) -> pass=1, count=10, identical to back-to-back.
- WIDTH=8, N=14; feed the correct series up to 233 (13 beats) -> fail=1, ovf=1, err_idx=13, count=13, pass=0.
- Restart: after 5 correct beats, pulse start with in_valid=1 and in_data=8 in the same cycle. That beat is not accepted, count=0. Then the full 10-term series -> pass=1, count=10.
- Drive rst low for 1 cycle after 6 correct beats -> all outputs 0 immediately, state IDLE. A subsequent start with the full series -> pass=1.
